// File: rtl/if_fetch_word_queue.sv
// Fetch-word producer: issues sequential word reads to a 1-cycle BRAM and
// queues the returned words with their PCs for the IF-stage aligner.
module if_fetch_word_queue #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_redirect,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic                       o_mem_en,
    output logic [XLEN-1:0]            o_mem_addr,
    input  logic [31:0]                i_mem_rdata,
    output logic                       o_word_valid,
    output logic [31:0]                o_word,
    output logic [XLEN-1:0]            o_word_pc,
    output logic                       o_word_skip_lo,
    input  logic                       i_word_ready,
    output logic [$clog2(DEPTH):0]     o_occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;
    logic            r_pending_skip;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [31:0]     r_q_word [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [DEPTH-1:0] r_q_skip;

    logic [CW:0]      w_outstanding;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_entry_we;
    logic             w_unused;

    // Credit counts only registered state, so a same-cycle pop never frees a slot early.
    assign w_outstanding = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue       = !i_reset && (w_outstanding < (CW+1)'(DEPTH));
    assign w_push        = r_inflight && !i_redirect;
    assign w_pop         = o_word_valid && i_word_ready;
    assign w_unused      = i_redirect_pc[0];

    assign o_mem_en       = w_issue;
    assign o_mem_addr     = r_fetch_pc;
    assign o_word_valid   = (r_count != '0);
    assign o_word         = r_q_word[r_rd_ptr];
    assign o_word_pc      = r_q_pc[r_rd_ptr];
    assign o_word_skip_lo = o_word_valid && r_q_skip[r_rd_ptr];
    assign o_occupancy    = r_count;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign w_entry_we[gi] = w_push && (r_wr_ptr == PW'(gi));
        end
    endgenerate

    // Queue payload is left unreset; o_word_valid qualifies it.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_we[i]) begin
                r_q_word[i] <= i_mem_rdata;
                r_q_pc[i]   <= r_inflight_pc;
                r_q_skip[i] <= r_pending_skip;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc     <= {RESET_VECTOR[XLEN-1:2], 2'b00};
            r_inflight     <= 1'b0;
            r_pending_skip <= 1'b0;
        end else if (i_redirect) begin
            r_fetch_pc     <= {i_redirect_pc[XLEN-1:2], 2'b00};
            r_inflight     <= 1'b0;
            r_pending_skip <= i_redirect_pc[1];
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_push) begin
                r_pending_skip <= 1'b0;
            end
        end
    end

    // A redirect flushes the queue even if the head is popped in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch_word_queue.sv
// Scenario bench for if_fetch_word_queue: BRAM model mem[a]=a^A5A5_0000 and
// a scoreboard queue of expected {word, pc, skip_lo} in delivery order.
module tb_if_fetch_word_queue;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        skip;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_mem_en;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_rdata = '0;
    logic        o_word_valid;
    logic [31:0] o_word;
    logic [31:0] o_word_pc;
    logic        o_word_skip_lo;
    logic        i_word_ready = 1'b0;
    logic [2:0]  o_occupancy;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    if_fetch_word_queue #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_mem_en       (o_mem_en),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rdata    (i_mem_rdata),
        .o_word_valid   (o_word_valid),
        .o_word         (o_word),
        .o_word_pc      (o_word_pc),
        .o_word_skip_lo (o_word_skip_lo),
        .i_word_ready   (i_word_ready),
        .o_occupancy    (o_occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_en) i_mem_rdata <= o_mem_addr ^ 32'hA5A5_0000;
    end

    function automatic void expect_word(input logic [31:0] pc, input logic skip);
        exp_t e;
        e.word = pc ^ 32'hA5A5_0000;
        e.pc   = pc;
        e.skip = skip;
        exp_q.push_back(e);
    endfunction

    task automatic start_after_reset(input logic ready);
        i_reset = 1'b1; i_redirect = 1'b0; i_word_ready = ready;
        exp_q.delete();
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({o_mem_en, o_word_valid, o_word_skip_lo, o_occupancy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: en/valid/skip/occ = %b/%b/%b/%0d, required 0/0/0/0",
                     o_mem_en, o_word_valid, o_word_skip_lo, o_occupancy);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        start_after_reset(1'b1);
        for (int k = 0; k < 10; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_mem_en !== 1'b1 || o_mem_addr !== 32'(4*(c-1))) begin
                n_fail++;
                $display("FAIL stream_issue c%0d: en=%b addr=%h, required en=1 addr=%h",
                         c, o_mem_en, o_mem_addr, 32'(4*(c-1)));
            end
            n_checks++;
            if (o_word_valid !== (c >= 3)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: %b, required %b", c, o_word_valid, c >= 3);
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL stream_word: %h/%h/%b, required %h/%h/%b",
                                 o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   occ_exp;
        start_after_reset(1'b0);
        for (int k = 0; k < 12; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 20; c++) begin
            i_word_ready = (c >= 9);
            @(negedge clk);
            if (c <= 9) begin
                occ_exp = (c <= 2) ? 0 : ((c - 2 > 4) ? 4 : c - 2);
                n_checks++;
                if (o_mem_en !== (c <= 4) || o_occupancy !== 3'(occ_exp)) begin
                    n_fail++;
                    $display("FAIL bp_credit c%0d: en=%b occ=%0d, required en=%b occ=%0d",
                             c, o_mem_en, o_occupancy, c <= 4, occ_exp);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL bp_word: %h/%h/%b, required %h/%h/%b",
                                 o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_halfword();
        exp_t e;
        start_after_reset(1'b1);
        for (int k = 0; k < 4; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (c == 6) begin
                i_redirect = 1'b1; i_redirect_pc = 32'h0000_0102;
                expect_word(32'h100, 1'b1);
                for (int k = 1; k < 4; k++) expect_word(32'h100 + 32'(4*k), 1'b0);
            end
            @(negedge clk);
            if (c == 7) begin
                n_checks++;
                if (o_mem_en !== 1'b1 || o_mem_addr !== 32'h100 || o_occupancy !== 3'd0) begin
                    n_fail++;
                    $display("FAIL redir_issue: en=%b addr=%h occ=%0d, required 1/00000100/0",
                             o_mem_en, o_mem_addr, o_occupancy);
                end
            end
            if (c == 7 || c == 8) begin
                n_checks++;
                if (o_word_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_stale c%0d: valid=%b pc=%h, required valid=0", c, o_word_valid, o_word_pc);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL redir_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL redir_word c%0d: %h/%h/%b, required %h/%h/%b",
                                 c, o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
            i_redirect = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL redir_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_pop_pending();
        exp_t e;
        start_after_reset(1'b1);
        for (int k = 0; k < 3; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) begin
                i_redirect = 1'b1; i_redirect_pc = 32'h0000_0400;
                for (int k = 0; k < 4; k++) expect_word(32'h400 + 32'(4*k), 1'b0);
            end
            @(negedge clk);
            if (c == 6) begin
                n_checks++;
                if (o_occupancy !== 3'd0 || o_word_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rpp_flush: occ=%0d valid=%b, required 0/0", o_occupancy, o_word_valid);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rpp_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL rpp_word c%0d: %h/%h/%b, required %h/%h/%b",
                                 c, o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
            i_redirect = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rpp_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        start_after_reset(1'b1);
        for (int k = 0; k < 3; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 12; c++) begin
            if (c == 5) begin
                i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
            end
            if (c == 6) begin
                i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
                for (int k = 0; k < 4; k++) expect_word(32'h300 + 32'(4*k), 1'b0);
            end
            @(negedge clk);
            if (c == 7) begin
                n_checks++;
                if (o_mem_en !== 1'b1 || o_mem_addr !== 32'h300) begin
                    n_fail++;
                    $display("FAIL b2b_issue: en=%b addr=%h, required 1/00000300", o_mem_en, o_mem_addr);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL b2b_word c%0d: %h/%h/%b, required %h/%h/%b",
                                 c, o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
            i_redirect = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        start_after_reset(1'b0);
        for (int k = 0; k < 3; k++) expect_word(32'(4*k), 1'b0);
        for (int c = 1; c <= 10; c++) begin
            i_reset      = (c == 5);
            i_word_ready = (c >= 6);
            @(negedge clk);
            if (c == 5) begin
                n_checks++;
                if (o_occupancy !== 3'd3 || o_mem_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_mid_pre: occ=%0d en=%b, required 3/0", o_occupancy, o_mem_en);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (o_word_valid !== 1'b0 || o_occupancy !== 3'd0 || o_mem_en !== 1'b1 || o_mem_addr !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rst_mid_post: valid=%b occ=%0d en=%b addr=%h, required 0/0/1/00000000",
                             o_word_valid, o_occupancy, o_mem_en, o_mem_addr);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_mid_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL rst_mid_word c%0d: %h/%h/%b, required %h/%h/%b",
                                 c, o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
        end
        i_reset = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_pc_wrap();
        exp_t e;
        start_after_reset(1'b1);
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) begin
                i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
                expect_word(32'hFFFF_FFFC, 1'b0);
                for (int k = 0; k < 3; k++) expect_word(32'(4*k), 1'b0);
            end
            @(negedge clk);
            if (c == 3) begin
                n_checks++;
                if (o_mem_en !== 1'b1 || o_mem_addr !== 32'h0) begin
                    n_fail++;
                    $display("FAIL wrap_issue: en=%b addr=%h, required 1/00000000", o_mem_en, o_mem_addr);
                end
            end
            if (o_word_valid && i_word_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_extra: pc=%h, required no word", o_word_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_word !== e.word || o_word_pc !== e.pc || o_word_skip_lo !== e.skip) begin
                        n_fail++;
                        $display("FAIL wrap_word c%0d: %h/%h/%b, required %h/%h/%b",
                                 c, o_word, o_word_pc, o_word_skip_lo, e.word, e.pc, e.skip);
                    end
                end
            end
            @(posedge clk); #1;
            i_redirect = 1'b0;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_halfword();
        test_redirect_pop_pending();
        test_back_to_back();
        test_reset_midstream();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
